// File: rtl/mem_load_stage_pkg.sv
// Load-op one-hot indices, MEM load FSM states and shared helpers for mem_load_stage.
package mem_load_stage_pkg;

  localparam int LOAD_OP_W   = 6;
  localparam int LOAD_OP_LW  = 0;
  localparam int LOAD_OP_LB  = 1;
  localparam int LOAD_OP_LBU = 2;
  localparam int LOAD_OP_LH  = 3;
  localparam int LOAD_OP_LHU = 4;
  localparam int LOAD_OP_LD  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Width of the forwarding bus {valid, we, waddr, wdata}.
  function automatic int fwd_w(input int rf_aw, input int data_w);
    return 2 + rf_aw + data_w;
  endfunction

  // A dword load on a 32-bit datapath can never be satisfied, so it always traps.
  function automatic logic load_misaligned(input logic [LOAD_OP_W-1:0] op,
                                           input logic [2:0]           addr,
                                           input logic                 wide);
    return ((op[LOAD_OP_LH] | op[LOAD_OP_LHU]) & addr[0])
         | (op[LOAD_OP_LW] & (|addr[1:0]))
         | (op[LOAD_OP_LD] & (~wide | (|addr[2:0])));
  endfunction

endpackage

// File: rtl/mem_load_stage_load_align.sv
// Combinational load lane extraction and sign/zero extension plus misalignment flag.
// Latency 0; no flow control.
module mem_load_stage_load_align
  import mem_load_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LOAD_OP_W-1:0]            op,
  input  logic [$clog2(DATA_W/8)-1:0]     lane,
  input  logic [DATA_W-1:0]               rdata,
  output logic [DATA_W-1:0]               data,
  output logic                            misaligned
);
  localparam int LB_W = $clog2(DATA_W/8);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Masking the low lane bits keeps half/word selects naturally aligned for either width.
  assign byte_v = 8'(rdata >> {lane, 3'b000});
  assign half_v = 16'(rdata >> {lane & ~LB_W'(1), 3'b000});
  assign word_v = 32'(rdata >> {lane & ~LB_W'(3), 3'b000});

  always_comb begin
    data = rdata;
    if (op[LOAD_OP_LB])  data = DATA_W'($signed(byte_v));
    if (op[LOAD_OP_LBU]) data = DATA_W'(byte_v);
    if (op[LOAD_OP_LH])  data = DATA_W'($signed(half_v));
    if (op[LOAD_OP_LHU]) data = DATA_W'(half_v);
    if (op[LOAD_OP_LW])  data = DATA_W'($signed(word_v));
  end

  assign misaligned = load_misaligned(op, 3'(lane), DATA_W == 64);

endmodule

// File: rtl/mem_load_stage.sv
// MEM stage: EX->MEM register, waits for SRAM read data, drives WB/forwarding (non-loads latency 0).
// Backpressure: stall_in or an outstanding load holds the register; stall_req asks upstream to hold.
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int PC_W   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall_in,
  input  logic                             flush,
  input  logic                             ex_valid,
  input  logic [PC_W-1:0]                  ex_pc,
  input  logic [LOAD_OP_W-1:0]             ex_load_op,
  input  logic                             ex_rf_we,
  input  logic [RF_AW-1:0]                 ex_rf_waddr,
  input  logic [DATA_W-1:0]                ex_result,
  input  logic                             data_rvalid,
  input  logic [DATA_W-1:0]                data_rdata,
  output logic                             stall_req,
  output logic                             addr_exc,
  output logic                             wb_valid,
  output logic [PC_W-1:0]                  wb_pc,
  output logic                             wb_rf_we,
  output logic [RF_AW-1:0]                 wb_rf_waddr,
  output logic [DATA_W-1:0]                wb_rf_wdata,
  output logic [fwd_w(RF_AW, DATA_W)-1:0]  fwd_bus
);
  localparam int LB_W = $clog2(DATA_W/8);

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [LOAD_OP_W-1:0]   op_q, op_d;
  logic                   we_q, we_d;
  logic [RF_AW-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic                   accept, ex_wait, busy, is_load, load_mis, exc;
  logic [DATA_W-1:0]      load_data;

  // DONE also accepts the next instruction so a completed load costs no bubble.
  assign accept  = ~flush & ~stall_in & (state_q == ST_IDLE || state_q == ST_DONE);
  assign ex_wait = ex_valid & (|ex_load_op) & ~load_misaligned(ex_load_op, ex_result[2:0], DATA_W == 64);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    op_d     = op_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    result_d = result_q;
    rdata_d  = rdata_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = ex_valid;
      pc_d     = ex_pc;
      op_d     = ex_load_op;
      we_d     = ex_rf_we;
      waddr_d  = ex_rf_waddr;
      result_d = ex_result;
      rdata_d  = '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (flush)          state_d = ST_IDLE;
        else if (!stall_in) state_d = ex_wait ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (data_rvalid) begin
          state_d = flush ? ST_IDLE : ST_DONE;
          if (!flush) rdata_d = data_rdata;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The killed load's response is still in flight; swallow it before going idle.
        if (data_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      op_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
      rdata_q  <= rdata_d;
    end
  end

  mem_load_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
    .op         (op_q),
    .lane       (result_q[LB_W-1:0]),
    .rdata      (rdata_q),
    .data       (load_data),
    .misaligned (load_mis)
  );

  assign busy        = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign is_load     = |op_q;
  assign exc         = valid_q & is_load & load_mis;
  assign stall_req   = busy;
  assign addr_exc    = exc;
  assign wb_valid    = valid_q & ~busy;
  assign wb_pc       = pc_q;
  assign wb_rf_we    = wb_valid & we_q & ~exc;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_load ? load_data : result_q;
  assign fwd_bus     = {wb_valid, wb_rf_we, wb_rf_waddr, wb_rf_wdata};

endmodule
